// File: rtl/risc16_memsys_pkg.sv
// Shared types and MMIO map offsets for the risc16 memory subsystem.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package risc16_memsys_pkg;

    // Data-port FSM states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } dstate_t;

    // Byte offsets inside the 256-byte MMIO window
    localparam logic [7:0] LED_OFF = 8'h00;
    localparam logic [7:0] CNT_OFF = 8'h10;

    // Big-endian lanes: lane 0 is the lowest byte address and the MSB byte of the word.
    // Returns the LSB bit position of that lane; the matching byte enable is lane_lsb/8.
    function automatic int lane_lsb(input int be_w, input int lane);
        return 8 * (be_w - 1 - lane);
    endfunction

endpackage

// File: rtl/risc16_dpram.sv
// Word RAM with one byte-enabled write/read port (A) and one read-only port (B).
// Latency: both reads registered, data valid the cycle after the read enable.
// Backpressure: none; every enabled access completes on the clock edge.
module risc16_dpram #(
    parameter int DATA_W = 16,
    parameter int AW     = 15
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                a_we,
    input  logic [DATA_W/8-1:0] a_be,
    input  logic                a_re,
    input  logic [AW-1:0]       a_addr,
    input  logic [DATA_W-1:0]   a_wdata,
    output logic [DATA_W-1:0]   a_rdata,
    input  logic                b_re,
    input  logic [AW-1:0]       b_addr,
    output logic [DATA_W-1:0]   b_rdata
);
    logic [DATA_W-1:0] mem [0:(2**AW)-1];

    // Byte-lane writes; array contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (a_we) begin
            for (int i = 0; i < DATA_W / 8; i++) begin
                if (a_be[i]) mem[a_addr][8*i +: 8] <= a_wdata[8*i +: 8];
            end
        end
    end

    // Port A registered read; a same-edge write on this port is not visible yet.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)      a_rdata <= '0;
        else if (a_re) a_rdata <= mem[a_addr];
    end

    // Port B registered read; holds its last word while idle, returns pre-write data on collision.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)      b_rdata <= '0;
        else if (b_re) b_rdata <= mem[b_addr];
    end

endmodule

// File: rtl/risc16_memsys.sv
// RAM + LED MMIO behind a wait-stated data port, plus a fetch port; RISC16_MMIO_CYCLE_CNT_EN adds a cycle counter.
// Latency: d_ack WAIT_CYCLES+1 cycles after the accept edge; i_ack/i_rdata one cycle after i_req.
// Backpressure: d_req is taken only in IDLE (one access per WAIT_CYCLES+2 cycles), requests while busy are dropped.
module risc16_memsys
    import risc16_memsys_pkg::*;
#(
    parameter int                ADDR_W      = 16,
    parameter int                DATA_W      = 16,
    parameter int                MEM_AW      = 15,
    parameter int                LED_CH      = 3,
    parameter logic [ADDR_W-1:0] MMIO_BASE   = 16'h0200,
    parameter int                WAIT_CYCLES = 0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                d_req,
    input  logic                d_we,
    input  logic [DATA_W/8-1:0] d_be,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    output logic                d_ack,
    output logic [DATA_W-1:0]   d_rdata,
    input  logic                i_req,
    input  logic [ADDR_W-1:0]   i_addr,
    output logic                i_ack,
    output logic [DATA_W-1:0]   i_rdata,
    output logic [8*LED_CH-1:0] led
);
    localparam int BE_W = DATA_W / 8;
    localparam int LG   = $clog2(BE_W);

    dstate_t                state, state_nx;
    logic [3:0]             wait_cnt;
    logic                   acc;
    logic                   cap;
    logic                   mmio_live;
    logic                   mmio_q;
    logic                   ram_we;
    logic [MEM_AW-1:0]      idx_live, idx_q, ram_a_addr, i_idx;
    logic [7:0]             off_q, rd_off;
    logic [LED_CH-1:0][7:0] led_q;
    logic [DATA_W-1:0]      ram_a_q;
    logic [DATA_W-1:0]      mmio_rd_nx, mmio_rd_q;

    // Upper word-address bits fall away in the cast, giving the RAM wrap-around alias.
    assign idx_live   = MEM_AW'(d_addr >> LG);
    assign i_idx      = MEM_AW'(i_addr >> LG);
    assign mmio_live  = (d_addr[ADDR_W-1:8] == MMIO_BASE[ADDR_W-1:8]);
    assign acc        = (state == ST_IDLE) && d_req;
    assign ram_we     = acc && d_we && !mmio_live;
    // Reads are captured on the edge entering RESP: the accept edge itself when there are no waits.
    assign cap        = (state_nx == ST_RESP);
    assign ram_a_addr = (state == ST_IDLE) ? idx_live : idx_q;
    assign rd_off     = (state == ST_IDLE) ? d_addr[7:0] : off_q;
    assign led        = led_q;

    // FSM state register and wait-state down-counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= ST_IDLE;
            wait_cnt <= '0;
        end else begin
            state <= state_nx;
            if (acc)                    wait_cnt <= 4'(WAIT_CYCLES - 1);
            else if (state == ST_WAIT)  wait_cnt <= wait_cnt - 4'd1;
        end
    end

    // Next state plus data-port outputs; only RESP drives d_ack and non-zero d_rdata.
    always_comb begin
        state_nx = state;
        d_ack    = 1'b0;
        d_rdata  = '0;
        case (state)
            ST_IDLE: if (d_req) state_nx = (WAIT_CYCLES > 0) ? ST_WAIT : ST_RESP;
            ST_WAIT: if (wait_cnt == 4'd0) state_nx = ST_RESP;
            ST_RESP: begin
                state_nx = ST_IDLE;
                d_ack    = 1'b1;
                d_rdata  = mmio_q ? mmio_rd_q : ram_a_q;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    // Hold the accepted request's address and target for the WAIT/RESP phases.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idx_q  <= '0;
            off_q  <= '0;
            mmio_q <= 1'b0;
        end else if (acc) begin
            idx_q  <= idx_live;
            off_q  <= d_addr[7:0];
            mmio_q <= mmio_live;
        end
    end

`ifdef RISC16_MMIO_CYCLE_CNT_EN
    logic [DATA_W-1:0] cycle_cnt, cnt_q, cnt_sel;

    // Free-running cycle counter, wraps naturally.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) cycle_cnt <= '0;
        else      cycle_cnt <= cycle_cnt + DATA_W'(1);
    end

    // Snapshot the counter at accept so wait states do not skew the value read.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)     cnt_q <= '0;
        else if (acc) cnt_q <= cycle_cnt;
    end

    assign cnt_sel = (state == ST_IDLE) ? cycle_cnt : cnt_q;
`endif

    // Assemble the MMIO word at the capture edge; unmapped bytes stay 0.
    always_comb begin
        mmio_rd_nx = '0;
        for (int k = 0; k < LED_CH; k++) begin
            if ((int'(LED_OFF) + k) / BE_W == int'(rd_off) / BE_W)
                mmio_rd_nx[lane_lsb(BE_W, (int'(LED_OFF) + k) % BE_W) +: 8] = led_q[k];
        end
`ifdef RISC16_MMIO_CYCLE_CNT_EN
        if (int'(rd_off) / BE_W == int'(CNT_OFF) / BE_W) mmio_rd_nx = cnt_sel;
`endif
    end

    // Register MMIO read data alongside the RAM read.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)     mmio_rd_q <= '0;
        else if (cap) mmio_rd_q <= mmio_rd_nx;
    end

    // LED writes commit on the accept edge, one byte per enabled lane; other MMIO bytes discard writes.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            led_q <= '0;
        end else if (acc && d_we && mmio_live) begin
            for (int k = 0; k < LED_CH; k++) begin
                if (((int'(LED_OFF) + k) / BE_W == int'(d_addr[7:0]) / BE_W) &&
                    d_be[lane_lsb(BE_W, (int'(LED_OFF) + k) % BE_W) / 8])
                    led_q[k] <= d_wdata[lane_lsb(BE_W, (int'(LED_OFF) + k) % BE_W) +: 8];
            end
        end
    end

    // Fetch valid is simply the request delayed one cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) i_ack <= 1'b0;
        else      i_ack <= i_req;
    end

    risc16_dpram #(
        .DATA_W (DATA_W),
        .AW     (MEM_AW)
    ) u_ram (
        .clk     (clk),
        .rst     (rst),
        .a_we    (ram_we),
        .a_be    (d_be),
        .a_re    (cap),
        .a_addr  (ram_a_addr),
        .a_wdata (d_wdata),
        .a_rdata (ram_a_q),
        .b_re    (i_req),
        .b_addr  (i_idx),
        .b_rdata (i_rdata)
    );

endmodule

// File: tb/tb_risc16_memsys.sv
// Directed bench: u0 is the zero-wait default build, u3 adds three wait states.
// Latency: inputs driven on the falling edge, outputs sampled on the falling edge.
// Backpressure: n/a.
module tb_risc16_memsys;
    logic        clk = 1'b0;
    logic        rst, rst3;

    logic        d_req, d_we, d_ack, i_req, i_ack;
    logic [1:0]  d_be;
    logic [15:0] d_addr, d_wdata, d_rdata, i_addr, i_rdata;
    logic [23:0] led;

    logic        w_req, w_we, w_ack, w_ireq, w_iack;
    logic [1:0]  w_be;
    logic [15:0] w_addr, w_wdata, w_rdata, w_iaddr, w_irdata;
    logic [23:0] led3;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    risc16_memsys u0 (
        .clk(clk), .rst(rst), .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr),
        .d_wdata(d_wdata), .d_ack(d_ack), .d_rdata(d_rdata), .i_req(i_req), .i_addr(i_addr),
        .i_ack(i_ack), .i_rdata(i_rdata), .led(led)
    );

    risc16_memsys #(.WAIT_CYCLES(3)) u3 (
        .clk(clk), .rst(rst3), .d_req(w_req), .d_we(w_we), .d_be(w_be), .d_addr(w_addr),
        .d_wdata(w_wdata), .d_ack(w_ack), .d_rdata(w_rdata), .i_req(w_ireq), .i_addr(w_iaddr),
        .i_ack(w_iack), .i_rdata(w_irdata), .led(led3)
    );

    // One data access on u0 (s3=0) or u3 (s3=1); lat = edges from accept to the edge raising d_ack.
    task automatic access(input bit s3, input logic we, input logic [1:0] be, input logic [15:0] addr,
                          input logic [15:0] wdata, output logic [15:0] rdata, output int lat);
        @(negedge clk);
        if (s3) begin w_req = 1'b1; w_we = we; w_be = be; w_addr = addr; w_wdata = wdata; end
        else    begin d_req = 1'b1; d_we = we; d_be = be; d_addr = addr; d_wdata = wdata; end
        @(negedge clk);
        d_req = 1'b0;
        w_req = 1'b0;
        lat = 1;
        while (((s3 ? w_ack : d_ack) !== 1'b1) && lat < 16) begin
            @(negedge clk);
            lat++;
        end
        rdata = s3 ? w_rdata : d_rdata;
    endtask

    task automatic fetch(input logic [15:0] addr, output logic [15:0] data, output logic ack);
        @(negedge clk);
        i_req = 1'b1; i_addr = addr;
        @(negedge clk);
        i_req = 1'b0;
        data = i_rdata; ack = i_ack;
    endtask

    task automatic test_reset();
        rst = 1'b0; rst3 = 1'b0;
        #1;
        n_total++; if ({d_ack, i_ack, w_ack} !== 3'b000) $display("FAIL reset_acks got %b want 000", {d_ack, i_ack, w_ack}); else n_pass++;
        n_total++; if ({d_rdata, i_rdata} !== 32'h0) $display("FAIL reset_rdata got %h want 0", {d_rdata, i_rdata}); else n_pass++;
        n_total++; if ({led, led3} !== 48'h0) $display("FAIL reset_led got %h want 0", {led, led3}); else n_pass++;
        repeat (2) @(negedge clk);
        rst = 1'b1; rst3 = 1'b1;
    endtask

    task automatic test_write_read();
        logic [15:0] rd; int lat;
        access(0, 1'b1, 2'b11, 16'h0100, 16'hBEEF, rd, lat);
        n_total++; if (lat !== 1) $display("FAIL wr_latency got %0d want 1", lat); else n_pass++;
        access(0, 1'b0, 2'b11, 16'h0100, 16'h0000, rd, lat);
        n_total++; if (lat !== 1) $display("FAIL rd_latency got %0d want 1", lat); else n_pass++;
        n_total++; if (rd !== 16'hBEEF) $display("FAIL rd_data got %h want beef", rd); else n_pass++;
        @(negedge clk);
        n_total++; if ({d_ack, d_rdata} !== 17'h0) $display("FAIL ack_pulse got %h want 0", {d_ack, d_rdata}); else n_pass++;
    endtask

    task automatic test_byte_lanes();
        logic [15:0] rd; int lat; logic ack;
        access(0, 1'b1, 2'b01, 16'h0100, 16'h1234, rd, lat);
        access(0, 1'b0, 2'b11, 16'h0100, 16'h0000, rd, lat);
        n_total++; if (rd !== 16'hBE34) $display("FAIL be01_read got %h want be34", rd); else n_pass++;
        fetch(16'h0100, rd, ack);
        n_total++; if ({ack, rd} !== {1'b1, 16'hBE34}) $display("FAIL fetch got ack=%b %h want 1 be34", ack, rd); else n_pass++;
        @(negedge clk);
        n_total++; if ({i_ack, i_rdata} !== {1'b0, 16'hBE34}) $display("FAIL fetch_hold got ack=%b %h want 0 be34", i_ack, i_rdata); else n_pass++;
        access(0, 1'b1, 2'b11, 16'h0102, 16'h5566, rd, lat);
        access(0, 1'b1, 2'b10, 16'h0102, 16'hAA00, rd, lat);
        access(0, 1'b0, 2'b11, 16'h0102, 16'h0000, rd, lat);
        n_total++; if (rd !== 16'hAA66) $display("FAIL be10_read got %h want aa66", rd); else n_pass++;
    endtask

    task automatic test_collision();
        logic [15:0] rd; int lat;
        access(0, 1'b1, 2'b11, 16'h0104, 16'h2222, rd, lat);
        @(negedge clk);
        d_req = 1'b1; d_we = 1'b1; d_be = 2'b11; d_addr = 16'h0104; d_wdata = 16'h1111;
        i_req = 1'b1; i_addr = 16'h0104;
        @(negedge clk);
        d_req = 1'b0;
        n_total++; if (i_rdata !== 16'h2222) $display("FAIL collide_old got %h want 2222", i_rdata); else n_pass++;
        n_total++; if (d_ack !== 1'b1) $display("FAIL collide_ack got %b want 1", d_ack); else n_pass++;
        @(negedge clk);
        i_req = 1'b0;
        n_total++; if (i_rdata !== 16'h1111) $display("FAIL collide_new got %h want 1111", i_rdata); else n_pass++;
    endtask

    task automatic test_mmio();
        logic [15:0] rd, snap; int lat; logic ack;
        fetch(16'h0200, snap, ack);
        access(0, 1'b1, 2'b11, 16'h0200, 16'hA55A, rd, lat);
        access(0, 1'b1, 2'b10, 16'h0202, 16'h7E00, rd, lat);
        n_total++; if (led !== 24'h7E5AA5) $display("FAIL led_write got %h want 7e5aa5", led); else n_pass++;
        access(0, 1'b0, 2'b11, 16'h0204, 16'h0000, rd, lat);
        n_total++; if (rd !== 16'h0000) $display("FAIL unmapped_read got %h want 0", rd); else n_pass++;
        access(0, 1'b0, 2'b11, 16'h0200, 16'h0000, rd, lat);
        n_total++; if (rd !== 16'hA55A) $display("FAIL led01_read got %h want a55a", rd); else n_pass++;
        access(0, 1'b0, 2'b11, 16'h0202, 16'h0000, rd, lat);
        n_total++; if (rd !== 16'h7E00) $display("FAIL led2_read got %h want 7e00", rd); else n_pass++;
        access(0, 1'b1, 2'b11, 16'h0204, 16'hFFFF, rd, lat);
        n_total++; if (led !== 24'h7E5AA5) $display("FAIL unmapped_write got %h want 7e5aa5", led); else n_pass++;
        fetch(16'h0200, rd, ack);
        n_total++; if (rd !== snap) $display("FAIL ram_untouched got %h want %h", rd, snap); else n_pass++;
    endtask

    task automatic test_counter();
        logic [15:0] v1, v2; int lat;
        access(0, 1'b0, 2'b11, 16'h0210, 16'h0000, v1, lat);
        repeat (8) @(negedge clk);
        access(0, 1'b0, 2'b11, 16'h0210, 16'h0000, v2, lat);
`ifdef RISC16_MMIO_CYCLE_CNT_EN
        n_total++; if (v2 - v1 !== 16'd10) $display("FAIL cnt_delta got %0d want 10", v2 - v1); else n_pass++;
`else
        n_total++; if (v1 !== 16'h0) $display("FAIL cnt_off_1 got %h want 0", v1); else n_pass++;
        n_total++; if (v2 !== 16'h0) $display("FAIL cnt_off_2 got %h want 0", v2); else n_pass++;
`endif
    endtask

    task automatic test_wait_states();
        logic [15:0] rd; int lat;
        access(1, 1'b1, 2'b11, 16'h0300, 16'hCAFE, rd, lat);
        n_total++; if (lat !== 4) $display("FAIL w3_wr_latency got %0d want 4", lat); else n_pass++;
        @(negedge clk);
        w_req = 1'b1; w_we = 1'b0; w_be = 2'b11; w_addr = 16'h0300;
        @(negedge clk);
        w_we = 1'b1; w_wdata = 16'hDEAD;
        lat = 1;
        while (w_ack !== 1'b1 && lat < 16) begin
            @(negedge clk);
            lat++;
        end
        w_req = 1'b0; w_we = 1'b0;
        n_total++; if (lat !== 4) $display("FAIL w3_rd_latency got %0d want 4", lat); else n_pass++;
        n_total++; if (w_rdata !== 16'hCAFE) $display("FAIL w3_rd_data got %h want cafe", w_rdata); else n_pass++;
        access(1, 1'b0, 2'b11, 16'h0300, 16'h0000, rd, lat);
        n_total++; if (rd !== 16'hCAFE) $display("FAIL w3_busy_ignored got %h want cafe", rd); else n_pass++;
    endtask

    task automatic test_reset_mid_access();
        logic [15:0] rd; int lat; int acks;
        access(1, 1'b1, 2'b11, 16'h0200, 16'hFFFF, rd, lat);
        n_total++; if (led3 !== 24'h00FFFF) $display("FAIL w3_led got %h want 00ffff", led3); else n_pass++;
        @(negedge clk);
        w_req = 1'b1; w_we = 1'b1; w_be = 2'b11; w_addr = 16'h0400; w_wdata = 16'h4321;
        @(negedge clk);
        w_req = 1'b0; w_we = 1'b0;
        rst3 = 1'b0;
        #1;
        n_total++; if ({w_ack, led3} !== 25'h0) $display("FAIL abort_state got %h want 0", {w_ack, led3}); else n_pass++;
        acks = 0;
        repeat (2) begin @(negedge clk); if (w_ack === 1'b1) acks++; end
        rst3 = 1'b1;
        repeat (6) begin @(negedge clk); if (w_ack === 1'b1) acks++; end
        n_total++; if (acks !== 0) $display("FAIL abort_no_ack got %0d acks want 0", acks); else n_pass++;
        access(1, 1'b0, 2'b11, 16'h0400, 16'h0000, rd, lat);
        n_total++; if (rd !== 16'h4321) $display("FAIL abort_write_kept got %h want 4321", rd); else n_pass++;
    endtask

    initial begin
        rst = 1'b1; rst3 = 1'b1;
        d_req = 1'b0; d_we = 1'b0; d_be = 2'b00; d_addr = '0; d_wdata = '0; i_req = 1'b0; i_addr = '0;
        w_req = 1'b0; w_we = 1'b0; w_be = 2'b00; w_addr = '0; w_wdata = '0; w_ireq = 1'b0; w_iaddr = '0;
        #2;
        test_reset();
        test_write_read();
        test_byte_lanes();
        test_collision();
        test_mmio();
        test_counter();
        test_wait_states();
        test_reset_mid_access();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/risc16_memsys.md
RISC16_MEMSYS -- requirements
Module: risc16_memsys

Interface
REQ-001 SHALL have parameter ADDR_W, default 16: byte-address width.
REQ-002 SHALL have parameter DATA_W, default 16: word width, a multiple of 8; BE_W = DATA_W/8.
REQ-003 SHALL have parameter MEM_AW, default 15: RAM word-address width (2**MEM_AW words).
REQ-004 SHALL have parameter LED_CH, default 3, range 1..8: number of 8-bit LED registers.
REQ-005 SHALL have parameter MMIO_BASE, default 16'h0200, 256-byte aligned: MMIO window base.
REQ-006 SHALL have parameter WAIT_CYCLES, default 0, range 0..15: extra data-port wait states.
REQ-007 SHALL have port clk, input, 1: sole clock, rising edge.
REQ-008 SHALL have port rst, input, 1: asynchronous, active-low reset.
REQ-009 SHALL have port d_req, input, 1: data access request.
REQ-010 SHALL have port d_we, input, 1: 1 = write, 0 = read.
REQ-011 SHALL have port d_be, input, BE_W: byte-lane enables; lane 0 is the MSB byte at the lowest address.
REQ-012 SHALL have ports d_addr, input, ADDR_W, and d_wdata, input, DATA_W: byte address and write data.
REQ-013 SHALL have ports d_ack, output, 1, and d_rdata, output, DATA_W: completion pulse and read data.
REQ-014 SHALL have ports i_req, input, 1, and i_addr, input, ADDR_W: instruction fetch request and address.
REQ-015 SHALL have ports i_ack, output, 1, and i_rdata, output, DATA_W: fetch valid and fetch word.
REQ-016 SHALL have port led, output, 8*LED_CH: LED register k drives bits [8k+7:8k].

Function
REQ-017 Word index SHALL be d_addr >> log2(BE_W), taken modulo 2**MEM_AW; upper address bits SHALL be ignored (wrap-around).
REQ-018 Data FSM states: IDLE, WAIT, RESP.
- IDLE with d_req=1: accept the request and latch addr, we, be and wdata.
- Go to WAIT if WAIT_CYCLES>0, else go to RESP.
- WAIT: stay exactly WAIT_CYCLES cycles, then go to RESP.
- RESP: d_ack=1 for one cycle, then return to IDLE.
REQ-019 d_req outside IDLE SHALL be ignored; access latency is WAIT_CYCLES+1 cycles from the accept edge to d_ack; throughput is one access per WAIT_CYCLES+2 cycles.
REQ-020 Writes SHALL commit on the accept edge, enabled lanes only; disabled lanes SHALL be unchanged.
REQ-021 d_rdata SHALL be valid only while d_ack=1 and SHALL be 0 otherwise. Read data is captured on the edge entering RESP.
REQ-022 MMIO decode: d_addr[ADDR_W-1:8] == MMIO_BASE[ADDR_W-1:8]. MMIO accesses SHALL never touch RAM.
REQ-023 LED register k SHALL be at byte address MMIO_BASE+k. A write SHALL update LED k only if its containing lane is enabled. A read SHALL return the LED value in its lane.
REQ-024 Unmapped MMIO bytes SHALL read 0; writes to them SHALL be discarded.
REQ-025 Instruction port: i_ack SHALL equal i_req delayed one cycle. i_rdata SHALL hold the RAM word at i_addr sampled at that edge. No MMIO decode applies; the fetch reads the RAM alias.
REQ-026 If a data write and a fetch hit the same word on the same edge, the fetch SHALL return the pre-write data.

Reset
REQ-027 On rst low, asynchronously: FSM=IDLE, d_ack=0, d_rdata=0, i_ack=0, i_rdata=0, led=0, cycle counter=0.
REQ-028 Reset mid-access SHALL abort without d_ack. A write already committed at accept SHALL persist. RAM contents SHALL NOT be reset.

Configuration
REQ-029 With RISC16_MMIO_CYCLE_CNT_EN defined:
- a DATA_W-bit free-running counter SHALL increment every cycle out of reset and wrap to 0;
- it SHALL be read-only at word address MMIO_BASE+16'h10;
- a read SHALL return the value at the accept edge.
REQ-030 Without RISC16_MMIO_CYCLE_CNT_EN, no counter logic SHALL exist and MMIO_BASE+16'h10 SHALL read 0.

Structure
REQ-031 Package risc16_memsys_pkg SHALL hold the FSM state enum, the LED offset (8'h00) and the counter offset (8'h10).
REQ-032 RAM SHALL be sub-module risc16_dpram: one byte-lane write/read port, one read port, both reads registered.

Verification
REQ-033 WAIT_CYCLES=0: write 16'hBEEF to 16'h0100 with be=2'b11, then read it -> d_ack one cycle after each accept; read returns 16'hBEEF.
REQ-034 Write be=2'b01 with data 16'h1234 to 16'h0100 -> read returns 16'hBE34; fetch of 16'h0100 returns 16'hBE34 one cycle later.
REQ-035 LED_CH=3: write 16'hA55A to 16'h0200 with be=2'b11, then 16'h7Exx to 16'h0202 with be=2'b10 -> led=24'h7E5AA5; read of 16'h0204 returns 0; RAM at 16'h0200 is unchanged.
REQ-036 WAIT_CYCLES=3: read accepted at cycle N -> d_ack at N+4. d_req pulses during N+1..N+3 are ignored.
REQ-037 Assert rst low during WAIT of a write -> no d_ack; led=0; a subsequent read returns the written data.
REQ-038 With RISC16_MMIO_CYCLE_CNT_EN: two reads of 16'h0210 accepted 10 cycles apart -> values differ by 10; without the macro both reads return 0.
